// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared widths, opcodes, FSM states for the ALU issue stage
package alu_issue_ctrl_pkg;

  localparam int ALU_W_IN  = 4;
  localparam int ALU_W_OUT = 8;
  localparam int OP_W      = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_7   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Packed FIFO word is {tag, op, a, b}
  function automatic int instr_width(input int tag_w);
    return tag_w + OP_W + 2 * ALU_W_IN;
  endfunction

endpackage

// File: rtl/alu_instr_fifo.sv
// rtl/alu_instr_fifo.sv - show-ahead instruction FIFO with wrap-bit full/empty detection
module alu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - buffers tagged instructions, drives the combinational ALU, captures results
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_a,
  input  logic [3:0]             in_b,
  input  logic [2:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_opcode,
  input  logic [7:0]             alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int IW = instr_width(TAG_W);

  state_e               state_q;
  logic                 init_q;
  logic [TAG_W-1:0]     tag_q;
  logic [ALU_W_IN-1:0]  alu_a_q, alu_b_q;
  logic [OP_W-1:0]      alu_op_q;
  logic                 out_valid_q;
  logic [ALU_W_OUT-1:0] out_result_q;
  logic [TAG_W-1:0]     out_tag_q;

  logic                 fifo_full, fifo_empty, push_d, pop_d;
  logic [IW-1:0]        head;
  logic [TAG_W-1:0]     head_tag;
  logic [OP_W-1:0]      head_op;
  logic [ALU_W_IN-1:0]  head_a, head_b;

  alu_instr_fifo #(.DEPTH(DEPTH), .WIDTH(IW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_d),
    .wdata_i ({in_tag, in_op, in_a, in_b}),
    .pop_i   (pop_d),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // init_q holds in_ready low until the first edge after reset release
  assign in_ready = init_q && !fifo_full;
  assign push_d   = in_valid && in_ready;
  assign pop_d    = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_HOLD && out_ready));
  assign {head_tag, head_op, head_a, head_b} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      init_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      init_q <= 1'b1;
      case (state_q)
        S_IDLE: if (pop_d) state_q <= S_EXEC;
        S_EXEC: begin
          out_result_q <= alu_result;
          out_tag_q    <= tag_q;
          out_valid_q  <= 1'b1;
          state_q      <= S_HOLD;
        end
        S_HOLD: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= pop_d ? S_EXEC : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      tag_q    <= '0;
    end else if (pop_d) begin
      alu_a_q  <= head_a;
      alu_b_q  <= head_b;
      alu_op_q <= head_op;
      tag_q    <= head_tag;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural alu_top
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [3:0] in_a, in_b;
  logic [2:0] in_op;
  logic [3:0] in_tag;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [3:0] out_tag;
  logic       busy;
  logic [2:0] fifo_level;

  int applied = 0;
  int miscompares = 0;
  int n_results = 0;
  int max_lvl = 0;
  logic stream_on = 1'b0;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .busy(busy), .fifo_level(fifo_level)
  );

  function automatic logic [7:0] golden(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  return {4'b0, a} + {4'b0, b};
      OP_SUB:  return {4'b0, a} - {4'b0, b};
      OP_AND:  return {4'b0, a & b};
      OP_OR:   return {4'b0, a | b};
      OP_XOR:  return {4'b0, a ^ b};
      OP_MUL:  return {4'b0, a} * {4'b0, b};
      OP_SHL:  return {4'b0, a} << b[1:0];
      default: return {a, b};
    endcase
  endfunction

  assign alu_result = golden(alu_a, alu_b, alu_opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [3:0] tag, input logic [7:0] exp);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({tag, exp});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sb_empty", exp_q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (stream_on && int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    if (rst_n && out_valid && out_ready) begin
      n_results++;
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_result: got tag 0x%0h result 0x%0h, none expected", out_tag, out_result);
      end else begin
        chk("result_tag_data", {20'b0, out_tag, out_result}, {20'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sweep_exp [8];
    int n0;
    sweep_exp = '{8'h16, 8'h02, 8'h08, 8'h0E, 8'h06, 8'h78, 8'h30, 8'hCA};
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("in_ready_after_release", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_first_edge", 32'(in_ready), 32'd1);

    // Single instruction latency
    out_ready = 1'b1;
    push(4'h3, 4'h1, OP_ADD, 4'h5, 8'h04);
    chk("lat_out_valid_k0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_alu_a", 32'(alu_a), 32'h3);
    chk("lat_alu_b", 32'(alu_b), 32'h1);
    chk("lat_alu_op", 32'(alu_opcode), 32'h0);
    chk("lat_out_valid_k1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_out_valid_k2", 32'(out_valid), 32'd1);
    chk("lat_out_result", 32'(out_result), 32'h04);
    chk("lat_out_tag", 32'(out_tag), 32'h5);
    drain();

    // Back-pressure fill, then pop while full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'(i), 4'h1, OP_ADD, 4'(i), 8'(i + 1));
    chk("bp_level_full", 32'(fifo_level), 32'd4);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_tag", 32'(out_tag), 32'd0);
    fork
      push(4'h5, 4'h1, OP_ADD, 4'h5, 8'h06);
      begin
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        chk("after_pop_level", 32'(fifo_level), 32'd3);
      end
    join
    drain();

    // Opcode sweep
    for (int i = 0; i < 8; i++) push(4'b1100, 4'b1010, 3'(i), 4'(i), sweep_exp[i]);
    drain();

    // Reset during HOLD with three queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'(i), 4'h2, OP_ADD, 4'(9 + i), 8'(i + 2));
    chk("mid_level", 32'(fifo_level), 32'd3);
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_alu", {20'b0, alu_a, alu_b, alu_opcode, 1'b0}, 32'd0);
    chk("arst_out_result", 32'(out_result), 32'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(4'h7, 4'h2, OP_XOR, 4'hA, 8'h05);
    @(posedge clk); #1;
    chk("post_rst_alu_a", 32'(alu_a), 32'h7);
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_result", 32'(out_result), 32'h05);
    chk("post_rst_tag", 32'(out_tag), 32'hA);
    drain();

    // Steady stream at the sustainable rate
    n0 = n_results;
    max_lvl = 0;
    stream_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] ra, rb;
      logic [2:0] rop;
      ra = 4'($urandom); rb = 4'($urandom); rop = 3'($urandom);
      push(ra, rb, rop, 4'(i), golden(ra, rb, rop));
      @(posedge clk); #1;
    end
    drain();
    stream_on = 1'b0;
    chk("stream_count", 32'(n_results - n0), 32'd20);
    chk("stream_max_level_le1", 32'(max_lvl <= 1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
